vec_mem_readout: RTL and testbench

- Reader-side companion to the data memory the vector CPU writes into.
- On a start pulse, fetches a block of 16-lane vector words from data memory, starting at a region chosen by a 4-bit select (board switches).
- Serializes the fetched words lane-by-lane onto a valid/ready stream for a display or UART sink.
- Sits beside the CPU at top level and shares the data memory through a dedicated read port.

---
 rtl/vec_pkg.sv | 18 +
 rtl/lane_serializer.sv | 33 +++
 rtl/vec_mem_readout.sv | 129 ++++++++++++
 tb/tb_vec_mem_readout.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector data-memory readout path.
package vec_pkg;

   localparam int N          = 16;
   localparam int LANES      = 16;
   localparam int LANE_IDX_W = $clog2(LANES);

   typedef logic [LANES-1:0][N-1:0] vec_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SEND,
      DONE
   } readout_state_t;

endpackage

// File: rtl/lane_serializer.sv
// Holds one fetched vector word and presents it one lane at a time.
module lane_serializer
   import vec_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         advance_i,
   input  vec_t         vec_i,
   output logic [N-1:0] lane_o,
   output logic         last_lane_o
);

   vec_t                  lanes_q;
   logic [LANE_IDX_W-1:0] idx_q;

   // The index parks on the last lane; the next load rewinds it to lane 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes_q <= '0;
         idx_q   <= '0;
      end else if (load_i) begin
         lanes_q <= vec_i;
         idx_q   <= '0;
      end else if (advance_i && !last_lane_o) begin
         idx_q <= idx_q + LANE_IDX_W'(1);
      end
   end

   assign lane_o      = lanes_q[idx_q];
   assign last_lane_o = (idx_q == LANE_IDX_W'(LANES - 1));

endmodule

// File: rtl/vec_mem_readout.sv
// Reads a block of vector words from data memory and streams it out lane by lane
// over a valid/ready interface.
module vec_mem_readout
   import vec_pkg::*;
#(
   parameter int          BLOCK_WORDS = 16,
   parameter logic [31:0] BASE_ADDR   = 32'd0
)
(
   input  logic               CLK,
   input  logic               reset,
   input  logic               start,
   input  logic [3:0]         sel,
   output logic [31:0]        mem_addr,
   input  logic [LANES*N-1:0] mem_rdata,
   output logic [N-1:0]       out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic               done
);

   localparam int WORD_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

   readout_state_t    state_q, state_d;
   logic [3:0]        sel_q, sel_d;
   logic [WORD_W-1:0] word_idx_q, word_idx_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              xfer, last_lane, last_word, ser_load, ser_advance;

   function automatic logic [31:0] word_addr(input logic [3:0] s, input logic [WORD_W-1:0] w);
      return BASE_ADDR + 32'(s) * 32'(BLOCK_WORDS) + 32'(w);
   endfunction

   assign xfer      = out_valid_q & out_ready;
   assign last_word = (word_idx_q == WORD_W'(BLOCK_WORDS - 1));

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         word_idx_q  <= '0;
         mem_addr_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         word_idx_q  <= word_idx_d;
         mem_addr_q  <= mem_addr_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // done is registered off the DONE state, so it rises together with busy falling.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      word_idx_d  = word_idx_q;
      mem_addr_d  = mem_addr_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ser_load    = 1'b0;
      ser_advance = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sel_d      = sel;
               word_idx_d = '0;
               mem_addr_d = word_addr(sel, '0);
               busy_d     = 1'b1;
               state_d    = FETCH;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            ser_load    = 1'b1;
            out_valid_d = 1'b1;
            state_d     = SEND;
         end
         SEND: begin
            if (xfer) begin
               ser_advance = 1'b1;
               if (last_lane) begin
                  out_valid_d = 1'b0;
                  if (last_word) begin
                     state_d = DONE;
                  end else begin
                     word_idx_d = word_idx_q + WORD_W'(1);
                     mem_addr_d = word_addr(sel_q, word_idx_q + WORD_W'(1));
                     state_d    = FETCH;
                  end
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   lane_serializer u_serializer (
      .clk         (CLK),
      .rst_n       (reset),
      .load_i      (ser_load),
      .advance_i   (ser_advance),
      .vec_i       (mem_rdata),
      .lane_o      (out_data),
      .last_lane_o (last_lane)
   );

   assign mem_addr  = mem_addr_q;
   assign out_valid = out_valid_q;
   assign out_last  = (state_q == SEND) && last_lane && last_word;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_vec_mem_readout.sv
// Self-checking bench for vec_mem_readout against a block-level model of the
// expected lane stream, addresses and handshake timing.
module tb_vec_mem_readout;

   localparam int N     = 16;
   localparam int LANES = 16;
   localparam int BW    = 16;
   localparam int TOTAL = LANES * BW;

   logic               CLK;
   logic               reset;
   logic               start;
   logic [3:0]         sel;
   logic [31:0]        mem_addr;
   logic [LANES*N-1:0] mem_rdata;
   logic [N-1:0]       out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;
   logic               busy;
   logic               done;

   logic [N-1:0] memArr [256][LANES];
   int compared   = 0;
   int mismatched = 0;
   int cycleNo    = 0;

   vec_mem_readout #(.BLOCK_WORDS(BW), .BASE_ADDR(32'd0)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .start     (start),
      .sel       (sel),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Data memory read port: registered, one cycle of latency.
   always @(posedge CLK) begin
      for (int l = 0; l < LANES; l++) mem_rdata[l*N +: N] <= memArr[mem_addr[7:0]][l];
   end

   function automatic logic [N-1:0] expLane(input logic [3:0] s, input int k);
      return memArr[int'(s) * BW + k / LANES][k % LANES];
   endfunction

   function automatic logic [31:0] expAddr(input logic [3:0] s, input int k);
      return 32'(s) * 32'(BW) + 32'(k / LANES);
   endfunction

   task automatic fillPattern();
      for (int a = 0; a < 256; a++)
         for (int l = 0; l < LANES; l++) memArr[a][l] = 16'(a * 16 + l);
   endtask

   task automatic fillRandom();
      for (int a = 0; a < 256; a++)
         for (int l = 0; l < LANES; l++) memArr[a][l] = 16'($urandom);
   endtask

   task automatic stepCycle(input logic st, input logic [3:0] s, input logic rdy);
      start     = st;
      sel       = s;
      out_ready = rdy;
      @(posedge CLK);
      #1;
      cycleNo++;
   endtask

   task automatic doReset();
      start     = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      reset = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3 reset = 1'b0;
      #2;
      compared++;
      if ({out_valid, out_last, busy, done, out_data, mem_addr} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got v=%b l=%b b=%b d=%b data=%h addr=%h, expected all 0",
                  out_valid, out_last, busy, done, out_data, mem_addr);
      end
      repeat (2) @(posedge CLK);
      #1;
      reset = 1'b1;
      @(posedge CLK);
      #1;
      compared++;
      if ({busy, out_valid, done} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL idle_after_reset: got busy=%b valid=%b done=%b, expected 0 0 0", busy, out_valid, done);
      end
   endtask

   task automatic test_latency();
      logic [3:0] s;
      int validRun;
      fillRandom();
      s = 4'($urandom);
      stepCycle(1'b1, s, 1'b1);
      compared++;
      if (mem_addr !== expAddr(s, 0) || busy !== 1'b1 || out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL latency_t1: got addr=%h busy=%b valid=%b, expected addr=%h busy=1 valid=0",
                  mem_addr, busy, out_valid, expAddr(s, 0));
      end
      stepCycle(1'b0, s, 1'b1);
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL latency_t2: got valid=%b, expected 0", out_valid);
      end
      stepCycle(1'b0, s, 1'b1);
      compared++;
      if (out_valid !== 1'b1 || out_data !== expLane(s, 0)) begin
         mismatched++;
         $display("[TB] FAIL latency_t3: got valid=%b data=%h, expected valid=1 data=%h", out_valid, out_data, expLane(s, 0));
      end
      validRun = 1;
      for (int i = 0; i < LANES - 1; i++) begin
         stepCycle(1'b0, s, 1'b1);
         if (out_valid === 1'b1) validRun++;
      end
      compared++;
      if (validRun !== LANES) begin
         mismatched++;
         $display("[TB] FAIL latency_word_run: got %0d valid cycles, expected %0d", validRun, LANES);
      end
      stepCycle(1'b0, s, 1'b1);
      compared++;
      if (out_valid !== 1'b0 || mem_addr !== expAddr(s, LANES)) begin
         mismatched++;
         $display("[TB] FAIL latency_gap1: got valid=%b addr=%h, expected valid=0 addr=%h", out_valid, mem_addr, expAddr(s, LANES));
      end
      stepCycle(1'b0, s, 1'b1);
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL latency_gap2: got valid=%b, expected 0", out_valid);
      end
      stepCycle(1'b0, s, 1'b1);
      compared++;
      if (out_valid !== 1'b1 || out_data !== expLane(s, LANES)) begin
         mismatched++;
         $display("[TB] FAIL latency_word1: got valid=%b data=%h, expected valid=1 data=%h", out_valid, out_data, expLane(s, LANES));
      end
      doReset();
   endtask

   // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
   task automatic test_stream(input string name, input logic [3:0] s0, input int mode, input bit lateStart);
      int k, doneCount, doneCycle, startCycle;
      logic rdy, prevStall, prevLast;
      logic [N-1:0] prevData;
      k = 0; doneCount = 0; doneCycle = -1;
      prevStall = 1'b0; prevLast = 1'b0; prevData = '0;
      stepCycle(1'b1, s0, 1'b1);
      startCycle = cycleNo - 1;
      for (int i = 0; i < 2000; i++) begin
         if (prevStall) begin
            compared++;
            if ({out_valid, out_last, out_data} !== {1'b1, prevLast, prevData}) begin
               mismatched++;
               $display("[TB] FAIL %s stall_hold: got v=%b l=%b d=%h, expected v=1 l=%b d=%h",
                        name, out_valid, out_last, out_data, prevLast, prevData);
            end
         end
         if (doneCount == 0 && done !== 1'b1) begin
            compared++;
            if (busy !== 1'b1) begin
               mismatched++;
               $display("[TB] FAIL %s busy_held: got busy=%b at cycle %0d, expected 1", name, busy, cycleNo - startCycle);
            end
         end
         if (done === 1'b1) begin
            doneCount++;
            if (doneCycle < 0) doneCycle = cycleNo;
         end
         if (out_last === 1'b1) begin
            compared++;
            if (out_valid !== 1'b1 || k != TOTAL - 1) begin
               mismatched++;
               $display("[TB] FAIL %s last_position: got last at transfer %0d valid=%b, expected transfer %0d", name, k, out_valid, TOTAL - 1);
            end
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((i % 4) == 0) || ((i % 4) == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         if (out_valid === 1'b1 && rdy) begin
            compared++;
            if (out_data !== expLane(s0, k) || out_last !== (k == TOTAL - 1) || mem_addr !== expAddr(s0, k)) begin
               mismatched++;
               $display("[TB] FAIL %s transfer[%0d]: got data=%h last=%b addr=%h, expected data=%h last=%b addr=%h",
                        name, k, out_data, out_last, mem_addr, expLane(s0, k), (k == TOTAL - 1), expAddr(s0, k));
            end
            k++;
         end
         prevStall = (out_valid === 1'b1) && !rdy;
         prevData  = out_data;
         prevLast  = out_last;
         if (doneCycle >= 0 && cycleNo >= doneCycle + 3) break;
         stepCycle(lateStart && i == 9, lateStart ? 4'd3 : 4'($urandom), rdy);
      end
      compared++;
      if (k !== TOTAL) begin
         mismatched++;
         $display("[TB] FAIL %s transfer_count: got %0d, expected %0d", name, k, TOTAL);
      end
      compared++;
      if (doneCount !== 1) begin
         mismatched++;
         $display("[TB] FAIL %s done_count: got %0d pulses, expected 1", name, doneCount);
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL %s busy_after_done: got %b, expected 0", name, busy);
      end
      if (mode == 0) begin
         compared++;
         if (doneCycle - startCycle !== BW * (LANES + 2) + 2) begin
            mismatched++;
            $display("[TB] FAIL %s done_latency: got %0d cycles, expected %0d", name, doneCycle - startCycle, BW * (LANES + 2) + 2);
         end
      end
   endtask

   task automatic test_first_word_region();
      fillPattern();
      stepCycle(1'b1, 4'hF, 1'b0);
      stepCycle(1'b0, 4'hF, 1'b0);
      stepCycle(1'b0, 4'hF, 1'b0);
      compared++;
      if (out_valid !== 1'b1 || out_data !== 16'h0F00 || mem_addr !== 32'd240) begin
         mismatched++;
         $display("[TB] FAIL region_first: got valid=%b data=%h addr=%0d, expected valid=1 data=0f00 addr=240",
                  out_valid, out_data, mem_addr);
      end
      doReset();
   endtask

   task automatic test_done_window();
      logic [3:0] s, s2;
      bit gotLast;
      fillPattern();
      s = 4'($urandom);
      s2 = s ^ 4'h5;
      gotLast = 1'b0;
      stepCycle(1'b1, s, 1'b1);
      for (int i = 0; i < 400 && !gotLast; i++) begin
         if (out_valid === 1'b1 && out_last === 1'b1) gotLast = 1'b1;
         stepCycle(1'b0, s, 1'b1);
      end
      compared++;
      if (!gotLast || busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL done_state: got last_seen=%b busy=%b done=%b valid=%b, expected 1 1 0 0", gotLast, busy, done, out_valid);
      end
      stepCycle(1'b1, s2, 1'b1);
      compared++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL start_in_done_ignored: got done=%b busy=%b, expected done=1 busy=0", done, busy);
      end
      stepCycle(1'b1, s2, 1'b1);
      compared++;
      if (busy !== 1'b1 || done !== 1'b0 || mem_addr !== expAddr(s2, 0)) begin
         mismatched++;
         $display("[TB] FAIL start_after_done: got busy=%b done=%b addr=%h, expected busy=1 done=0 addr=%h", busy, done, mem_addr, expAddr(s2, 0));
      end
      doReset();
   endtask

   task automatic test_reset_mid();
      logic [3:0] s;
      int k, dones;
      fillPattern();
      s = 4'd2 + 4'($urandom_range(0, 12));
      k = 0;
      stepCycle(1'b1, s, 1'b1);
      for (int i = 0; i < 400 && k < 5 * LANES + 4; i++) begin
         if (out_valid === 1'b1) k++;
         stepCycle(1'b0, s, 1'b1);
      end
      compared++;
      if (out_valid !== 1'b1 || mem_addr !== expAddr(s, 5 * LANES + 4) || out_data !== expLane(s, 5 * LANES + 4)) begin
         mismatched++;
         $display("[TB] FAIL reach_word5: got valid=%b addr=%h data=%h, expected valid=1 addr=%h data=%h",
                  out_valid, mem_addr, out_data, expAddr(s, 5 * LANES + 4), expLane(s, 5 * LANES + 4));
      end
      #2 reset = 1'b0;
      #1;
      compared++;
      if ({out_valid, out_last, busy, done, out_data, mem_addr} !== '0) begin
         mismatched++;
         $display("[TB] FAIL async_abort: got v=%b l=%b b=%b d=%b data=%h addr=%h, expected all 0",
                  out_valid, out_last, busy, done, out_data, mem_addr);
      end
      dones = 0;
      repeat (3) begin
         @(posedge CLK);
         #1;
         if (done === 1'b1) dones++;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stepCycle(1'b0, s, 1'b1);
         if (done === 1'b1) dones++;
      end
      compared++;
      if (dones !== 0) begin
         mismatched++;
         $display("[TB] FAIL no_done_on_abort: got %0d done pulses, expected 0", dones);
      end
      k = 0;
      stepCycle(1'b1, 4'd1, 1'b1);
      for (int i = 0; i < 200 && k < 3 * LANES; i++) begin
         if (out_valid === 1'b1) begin
            compared++;
            if (out_data !== expLane(4'd1, k) || mem_addr !== expAddr(4'd1, k)) begin
               mismatched++;
               $display("[TB] FAIL restart[%0d]: got data=%h addr=%h, expected data=%h addr=%h",
                        k, out_data, mem_addr, expLane(4'd1, k), expAddr(4'd1, k));
            end
            k++;
         end
         stepCycle(1'b0, 4'd1, 1'b1);
      end
      compared++;
      if (k !== 3 * LANES) begin
         mismatched++;
         $display("[TB] FAIL restart_count: got %0d transfers, expected %0d", k, 3 * LANES);
      end
      doReset();
   endtask

   initial begin
      start     = 1'b0;
      sel       = 4'd0;
      out_ready = 1'b0;
      test_reset();
      test_latency();
      fillPattern();
      test_stream("basic", 4'd0, 0, 1'b0);
      test_first_word_region();
      test_stream("region", 4'hF, 0, 1'b0);
      fillPattern();
      test_stream("backpressure", 4'($urandom), 1, 1'b0);
      fillRandom();
      test_stream("random_ready", 4'($urandom), 2, 1'b0);
      fillRandom();
      test_stream("start_busy", 4'd9, 0, 1'b1);
      test_done_window();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
